sfr_bank_v2: RTL and testbench

//  Parametrised special-function-register bank on the CPU data bus: 16-bit prescaled timer with atomic read,
//  N_PWM glitch-free PWM channels, x4 quadrature counter, buffered 8N1 UART TX with status/overflow.

---
 rtl/sfr_pkg.sv | 46 ++++
 rtl/sfr_uart_tx.sv | 121 ++++++++++++
 rtl/sfr_bank_v2.sv | 176 +++++++++++++++++
 tb/tb_sfr_bank_v2.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// ============================================================================
//  Module : sfr_pkg
//  Brief  : Shared SFR address map, status bit positions, TX states and the
//           quadrature step decoder used by the SFR bank.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sfr_pkg;

  typedef enum logic [7:0] {
    SFR_NOP        = 8'd0,
    SFR_TMR0L      = 8'd1,
    SFR_TMR0H      = 8'd2,
    SFR_PRESCALE   = 8'd3,
    SFR_PWM_PERIOD = 8'd4,
    SFR_STATUS     = 8'd5,
    SFR_ENC        = 8'd6,
    SFR_SOUT       = 8'd7
  } sfr_addr_e;

  localparam logic [7:0] SFR_PWM_BASE = 8'd8;

  localparam int STAT_TX_IDLE   = 0;
  localparam int STAT_FIFO_FULL = 1;
  localparam int STAT_OVF       = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Returns {count_enable, count_down} for one sampled {A,B} transition.
  function automatic logic [1:0] quad_step(input logic [1:0] prev, input logic [1:0] cur);
    case ({prev, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: return 2'b10;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: return 2'b11;
      default:                                return 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sfr_uart_tx.sv
// ============================================================================
//  Module : sfr_uart_tx
//  Brief  : Byte FIFO feeding an 8N1 serial transmitter; reports full, idle
//           and dropped pushes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sfr_uart_tx
  import sfr_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic       o_idle,
  output logic       o_drop,
  output logic       o_tx
);

  localparam int            AW     = $clog2(FIFO_DEPTH);
  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  tx_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_empty;
  logic w_bit_done;
  logic w_pop;
  logic w_push_ok;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_bit_done = (r_cnt == C_LAST);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop      = !w_empty && ((r_state == TX_IDLE) || ((r_state == TX_STOP) && w_bit_done));
  assign w_push_ok  = i_push && (!o_full || w_pop);
  assign o_drop     = i_push && o_full && !w_pop;
  assign o_idle     = w_empty && (r_state == TX_IDLE);
  assign o_tx       = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_cnt <= w_bit_done ? '0 : r_cnt + CW'(1);
      case (r_state)
        TX_IDLE: begin
          r_cnt <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr[AW-1:0]];
            r_tx    <= 1'b0;
            r_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_bit_done) begin
            r_tx    <= r_shift[0];
            r_bit   <= '0;
            r_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_bit_done) begin
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= TX_STOP;
            end else begin
              r_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end
        end
        TX_STOP: begin
          if (w_bit_done) begin
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr[AW-1:0]];
              r_tx    <= 1'b0;
              r_state <= TX_START;
            end else begin
              r_state <= TX_IDLE;
            end
          end
        end
        default: r_state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sfr_bank_v2.sv
// ============================================================================
//  Module : sfr_bank_v2
//  Brief  : CPU-bus SFR bank: prescaled 16-bit timer with atomic read, PWM
//           channels, x4 quadrature counter and buffered UART TX.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sfr_bank_v2
  import sfr_pkg::*;
#(
  parameter int N_PWM        = 3,
  parameter int PWM_W        = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 217
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_addr,
  input  logic [7:0]       i_write_val,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [7:0]       o_read_val,
  output logic [N_PWM-1:0] o_pwm_out,
  input  logic             i_enc_a,
  input  logic             i_enc_b,
  output logic             o_uart_tx
);

  logic [7:0]       r_prescale;
  logic [7:0]       r_pcnt;
  logic [15:0]      r_tmr0;
  logic [7:0]       r_tmr0h_latch;
  logic [PWM_W-1:0] r_period;
  logic [PWM_W-1:0] r_pwm_cnt;
  logic [7:0]       r_enc;
  logic [2:0]       r_a_sync;
  logic [2:0]       r_b_sync;
  logic             r_ovf;

  logic             w_tick;
  logic             w_pwm_wrap;
  logic             w_wr_tmr;
  logic             w_wr_sout;
  logic             w_tx_full;
  logic             w_tx_idle;
  logic             w_tx_drop;
  logic [1:0]       w_qstep;
  logic [7:0]       w_status;
  logic [7:0]       w_rd;
  logic [PWM_W-1:0] w_duty [N_PWM];

  assign w_tick    = (r_pcnt == r_prescale);
  assign w_wr_tmr  = i_wr_en && ((i_addr == SFR_TMR0L) || (i_addr == SFR_TMR0H));
  assign w_wr_sout = i_wr_en && (i_addr == SFR_SOUT);

  // Prescaler and timer; a timer write restarts both and overrides any tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale    <= '0;
      r_pcnt        <= '0;
      r_tmr0        <= '0;
      r_tmr0h_latch <= '0;
    end else begin
      if (i_wr_en && (i_addr == SFR_PRESCALE)) r_prescale <= i_write_val;
      if (w_wr_tmr) begin
        r_tmr0 <= '0;
        r_pcnt <= '0;
      end else begin
        r_pcnt <= w_tick ? '0 : r_pcnt + 8'd1;
        if (w_tick) r_tmr0 <= r_tmr0 + 16'd1;
      end
      if (i_rd_en && (i_addr == SFR_TMR0L)) r_tmr0h_latch <= r_tmr0[15:8];
    end
  end

  assign w_pwm_wrap = w_tick && ((r_period == '0) || (r_pwm_cnt >= r_period));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_period  <= '0;
      r_pwm_cnt <= '0;
    end else begin
      if (i_wr_en && (i_addr == SFR_PWM_PERIOD)) r_period <= PWM_W'(i_write_val);
      if (w_pwm_wrap)  r_pwm_cnt <= '0;
      else if (w_tick) r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  generate
    for (genvar k = 0; k < N_PWM; k++) begin : g_pwm
      logic [PWM_W-1:0] r_duty;
      logic [PWM_W-1:0] r_duty_act;
      logic             r_out;

      // The active duty only follows the shadow at a period boundary.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_duty     <= '0;
          r_duty_act <= '0;
          r_out      <= 1'b0;
        end else begin
          if (i_wr_en && (i_addr == (SFR_PWM_BASE + 8'(k)))) r_duty <= PWM_W'(i_write_val);
          if (w_pwm_wrap) r_duty_act <= r_duty;
          r_out <= (r_period != '0) && (r_pwm_cnt < r_duty_act);
        end
      end

      assign w_duty[k]    = r_duty;
      assign o_pwm_out[k] = r_out;
    end
  endgenerate

  assign w_qstep = quad_step({r_a_sync[2], r_b_sync[2]}, {r_a_sync[1], r_b_sync[1]});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sync <= '0;
      r_b_sync <= '0;
      r_enc    <= '0;
    end else begin
      r_a_sync <= {r_a_sync[1:0], i_enc_a};
      r_b_sync <= {r_b_sync[1:0], i_enc_b};
      if (i_wr_en && (i_addr == SFR_ENC)) r_enc <= i_write_val;
      else if (w_qstep[1])                r_enc <= w_qstep[0] ? r_enc - 8'd1 : r_enc + 8'd1;
    end
  end

  sfr_uart_tx #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_wr_sout),
    .i_data (i_write_val),
    .o_full (w_tx_full),
    .o_idle (w_tx_idle),
    .o_drop (w_tx_drop),
    .o_tx   (o_uart_tx)
  );

  always_ff @(posedge clk) begin
    if (rst)                                        r_ovf <= 1'b0;
    else if (i_wr_en && (i_addr == SFR_STATUS))     r_ovf <= 1'b0;
    else if (w_tx_drop)                             r_ovf <= 1'b1;
  end

  always_comb begin
    w_status                 = '0;
    w_status[STAT_TX_IDLE]   = w_tx_idle;
    w_status[STAT_FIFO_FULL] = w_tx_full;
    w_status[STAT_OVF]       = r_ovf;
  end

  always_comb begin
    w_rd = 8'h00;
    case (i_addr)
      SFR_TMR0L:      w_rd = r_tmr0[7:0];
      SFR_TMR0H:      w_rd = r_tmr0h_latch;
      SFR_PRESCALE:   w_rd = r_prescale;
      SFR_PWM_PERIOD: w_rd = 8'(r_period);
      SFR_STATUS:     w_rd = w_status;
      SFR_ENC:        w_rd = r_enc;
      default:        w_rd = 8'h00;
    endcase
    for (int k = 0; k < N_PWM; k++) begin
      if (i_addr == (SFR_PWM_BASE + 8'(k))) w_rd = 8'(w_duty[k]);
    end
  end

  assign o_read_val = w_rd;

endmodule

`default_nettype wire

// File: tb/tb_sfr_bank_v2.sv
// ============================================================================
//  Module : tb_sfr_bank_v2
//  Brief  : Randomised self-checking bench for sfr_bank_v2 against a
//           behavioural model of timer, PWM, encoder and UART.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sfr_bank_v2;

  localparam int CPB = 4;
  localparam logic [7:0] A_TMR0L = 8'd1, A_TMR0H = 8'd2, A_PRESCALE = 8'd3, A_PERIOD = 8'd4,
                         A_STATUS = 8'd5, A_ENC = 8'd6, A_SOUT = 8'd7, A_DUTY0 = 8'd8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = '0, wval = '0;
  logic       wr = 1'b0, rd_en = 1'b0;
  logic [7:0] rdata;
  logic [2:0] pwm;
  logic       enc_a = 1'b0, enc_b = 1'b0;
  logic       txd;

  int n_checks = 0;
  int n_pass   = 0;
  bit rx_en    = 1'b1;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  sfr_bank_v2 #(.N_PWM(3), .PWM_W(8), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .i_addr(addr), .i_write_val(wval), .i_wr_en(wr), .i_rd_en(rd_en),
    .o_read_val(rdata), .o_pwm_out(pwm), .i_enc_a(enc_a), .i_enc_b(enc_b), .o_uart_tx(txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] v);
    addr = a; wval = v; wr = 1'b1;
    step();
    wr = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] v);
    addr = a; #1; v = rdata;
  endtask

  task automatic rd_strobe(input logic [7:0] a);
    addr = a; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    int i;
    for (i = 0; i < 2000; i++) begin
      sfr_read(A_STATUS, s);
      if (s[0]) break;
      step();
    end
    if (i == 2000) check("tx_idle_timeout", 0, 1);
    repeat (4) step();
  endtask

  task automatic wait_rise(output bit ok);
    logic p;
    ok = 1'b0;
    p  = pwm[0];
    for (int i = 0; i < 100; i++) begin
      step();
      if (!p && pwm[0]) begin ok = 1'b1; break; end
      p = pwm[0];
    end
    if (!ok) check("pwm_rise_timeout", 0, 1);
  endtask

  task automatic measure_pulse(output int hi, output int per);
    bit ok;
    hi = 0; per = 0;
    wait_rise(ok);
    if (ok) begin
      while (pwm[0] && hi < 100) begin hi++; per++; step(); end
      while (!pwm[0] && per < 200) begin per++; step(); end
    end
  endtask

  // Encoder model: position index on the Gray cycle 00,01,11,10.
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         enc_pos = 0;
  logic [7:0] enc_model = 8'h00;

  task automatic enc_move(input int delta);
    enc_pos = (enc_pos + delta + 4) % 4;
    if (delta == 1)       enc_model = enc_model + 8'd1;
    else if (delta == -1) enc_model = enc_model - 8'd1;
    {enc_a, enc_b} = gray[enc_pos];
    repeat (4) step();
  endtask

  // Serial receiver: samples each bit at its centre.
  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      step();
      if (rx_en && txd === 1'b0) begin
        repeat (CPB / 2) step();
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) step();
          b[i] = txd;
        end
        repeat (CPB) step();
        check("rx_stop_bit", txd, 1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] v, regm [16];
    logic [7:0] bytes [10];
    int hi, per, p, d, d1, n, cnt0, cnt1, a;
    bit ok;

    // ---------------- reset state ----------------
    repeat (3) step();
    check("rst_uart_tx", txd, 1);
    check("rst_pwm", pwm, 0);
    for (int i = 0; i < 16; i++) begin
      sfr_read(8'(i), v);
      check($sformatf("rst_reg%0d", i), v, (i == 5) ? 8'h01 : 8'h00);
      step();
    end
    rst = 1'b0;

    // ---------------- register file, random ----------------
    for (int i = 0; i < 16; i++) regm[i] = 8'h00;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0: a = 3;  1: a = 4;  2: a = 6;  3: a = 8;  4: a = 9;  5: a = 10;
        6: a = 0;  default: a = $urandom_range(11, 15);
      endcase
      v = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        addr = 8'(a); wval = v; wr = 1'b1; rd_en = 1'b1; #1;
        check("rdwr_old_value", rdata, regm[a]);
        step();
        wr = 1'b0; rd_en = 1'b0;
      end else begin
        sfr_write(8'(a), v);
      end
      if (a == 3 || a == 4 || a == 6 || a == 8 || a == 9 || a == 10) regm[a] = v;
      sfr_read(8'(a), v);
      check($sformatf("reg_rb%0d", a), v, regm[a]);
    end

    // ---------------- timer, directed atomic read ----------------
    sfr_write(A_PRESCALE, 8'd4);
    sfr_write(A_TMR0L, 8'hAA);
    repeat (50) step();
    sfr_read(A_TMR0L, v);
    check("tmr_after_50", v, 8'd10);
    rd_strobe(A_TMR0L);
    repeat (1500) step();
    sfr_read(A_TMR0H, v);
    check("tmr_hi_latched_old", v, 8'd0);
    sfr_read(A_TMR0L, v);
    check("tmr_lo_310", v, 8'h36);
    rd_strobe(A_TMR0L);
    sfr_read(A_TMR0H, v);
    check("tmr_hi_relatched", v, 8'd1);

    // ---------------- timer, random prescale ----------------
    for (int t = 0; t < 5; t++) begin
      p = $urandom_range(0, 7);
      n = $urandom_range(20, 400);
      sfr_write(A_PRESCALE, 8'(p));
      sfr_write(A_TMR0H, 8'($urandom));
      repeat (n) step();
      sfr_read(A_TMR0L, v);
      check("tmr_rand_lo", v, (n / (p + 1)) & 8'hFF);
      rd_strobe(A_TMR0L);
      sfr_read(A_TMR0H, v);
      check("tmr_rand_hi", v, ((n / (p + 1)) >> 8) & 8'hFF);
    end

    // ---------------- PWM directed ----------------
    sfr_write(A_PRESCALE, 8'd0);
    sfr_write(A_PERIOD, 8'd9);
    sfr_write(A_DUTY0, 8'd3);
    repeat (25) step();
    measure_pulse(hi, per);
    check("pwm_width3", hi, 3);
    check("pwm_period10", per, 10);
    wait_rise(ok);
    hi = 1;
    sfr_write(A_DUTY0, 8'd7);
    while (pwm[0] && hi < 100) begin hi++; step(); end
    check("pwm_no_midperiod_change", hi, 3);
    measure_pulse(hi, per);
    check("pwm_width7", hi, 7);
    check("pwm_period10_b", per, 10);

    // ---------------- PWM random ----------------
    for (int t = 0; t < 6; t++) begin
      p  = (t == 0) ? 0 : $urandom_range(1, 10);
      d  = $urandom_range(0, 12);
      d1 = $urandom_range(0, 12);
      sfr_write(A_PERIOD, 8'(p));
      sfr_write(A_DUTY0, 8'(d));
      sfr_write(A_DUTY0 + 8'd1, 8'(d1));
      repeat (30) step();
      cnt0 = 0; cnt1 = 0;
      for (int c = 0; c < 3 * (p + 1); c++) begin
        cnt0 += int'(pwm[0]);
        cnt1 += int'(pwm[1]);
        step();
      end
      check("pwm_rand_ch0", cnt0, (p == 0) ? 0 : 3 * ((d < p + 1) ? d : p + 1));
      check("pwm_rand_ch1", cnt1, (p == 0) ? 0 : 3 * ((d1 < p + 1) ? d1 : p + 1));
    end

    // ---------------- encoder ----------------
    sfr_write(A_ENC, 8'h00);
    enc_model = 8'h00;
    for (int i = 0; i < 4; i++) enc_move(1);
    sfr_read(A_ENC, v);
    check("enc_fwd4", v, 8'd4);
    for (int i = 0; i < 4; i++) enc_move(-1);
    sfr_read(A_ENC, v);
    check("enc_back0", v, 8'd0);
    enc_move(2);
    sfr_read(A_ENC, v);
    check("enc_illegal_ignored", v, 8'd0);
    enc_move(2);
    enc_move(-1);
    sfr_read(A_ENC, v);
    check("enc_wrap_ff", v, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       enc_move(1);
        1:       enc_move(-1);
        default: enc_move(2);
      endcase
      if (i == 20) begin
        v = 8'($urandom);
        sfr_write(A_ENC, v);
        enc_model = v;
      end
      if (i % 5 == 4) begin
        sfr_read(A_ENC, v);
        check("enc_rand", v, enc_model);
      end
    end

    // ---------------- UART single byte waveform ----------------
    sfr_write(A_SOUT, 8'h55);
    exp_q.push_back(8'h55);
    for (int i = 0; i < 10 * CPB; i++) begin
      step();
      check($sformatf("tx55_s%0d", i), txd,
            (i / CPB == 0) ? 1'b0 : (i / CPB == 9) ? 1'b1 : 1'((8'h55 >> (i / CPB - 1)) & 1));
      if (i == 10) begin
        sfr_read(A_STATUS, v);
        check("status_busy", v, 8'h00);
      end
    end
    repeat (3) step();
    sfr_read(A_STATUS, v);
    check("status_idle_again", v, 8'h01);

    // ---------------- FIFO overflow ----------------
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      sfr_write(A_SOUT, bytes[i]);
      if (i < 9) exp_q.push_back(bytes[i]);
    end
    sfr_read(A_STATUS, v);
    check("status_full_ovf", v, 8'h06);
    sfr_write(A_STATUS, 8'($urandom));
    sfr_read(A_STATUS, v);
    check("status_ovf_cleared", v, 8'h02);
    wait_idle();

    // ---------------- push into full FIFO as a slot frees ----------------
    for (int i = 0; i < 9; i++) begin
      v = 8'($urandom);
      sfr_write(A_SOUT, v);
      exp_q.push_back(v);
    end
    sfr_read(A_STATUS, v);
    check("status_full_no_ovf", v, 8'h02);
    repeat (4 * CPB * 2) step();
    v = 8'($urandom);
    sfr_write(A_SOUT, v);
    exp_q.push_back(v);
    sfr_read(A_STATUS, v);
    check("status_push_pop_full", v, 8'h02);
    wait_idle();

    // ---------------- random bursts ----------------
    for (int b = 0; b < 3; b++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom);
        sfr_write(A_SOUT, v);
        exp_q.push_back(v);
      end
      wait_idle();
    end

    check("rx_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("rx_byte%0d", i), rx_q[i], exp_q[i]);

    // ---------------- reset mid-frame ----------------
    rx_en = 1'b0;
    sfr_write(A_PERIOD, 8'd9);
    sfr_write(A_DUTY0, 8'd20);
    sfr_write(A_SOUT, 8'hA5);
    repeat (4 * CPB) step();
    check("pwm_const_high", pwm[0], 1);
    check("tx_mid_frame_bit", txd, 1'b1 ^ 1'b1 ^ 1'((8'hA5 >> 2) & 1));
    rst = 1'b1;
    step();
    check("rst_mid_tx", txd, 1);
    check("rst_mid_pwm", pwm, 0);
    sfr_read(A_STATUS, v);
    check("rst_mid_status", v, 8'h01);
    rst = 1'b0;
    repeat (3 * CPB) step();
    check("rst_tx_stays_idle", txd, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
